// File: rtl/dual_issue_pair_reg.sv
// Fetch/decode boundary register for the dual-issue front end.
// Classifies the fetched pair (InstrA at PCF, InstrB at PCF+4) as dual-issuable
// or single-issue. It drives the fetch-stage selects and registers the issued
// slot(s) together with their valid bits. It also keeps saturating issue
// statistics.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   InstrA, InstrB    fetched instructions at PCF and PCF+4
//   PCF               PC of InstrA
//   StallD, FlushD    hold / squash the decode register (flush wins)
//   IncrSrc           to fetch: 1 = PC+8 (pair issued), 0 = PC+4
//   PCSrc             to fetch: 1 = hold PC (mirrors StallD)
//   InstrAD, InstrBD  registered slot instructions
//   ValidAD, ValidBD  slot holds a real instruction
//   PCAD, PCBD        slot PCs (PCBD = PCAD + 4)
//   DualCount         saturating count of pair issues
//   SingleCount       saturating count of single issues
module dual_issue_pair_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrA,
  input  logic [DATA_WIDTH-1:0] InstrB,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  IncrSrc,
  output logic                  PCSrc,
  output logic [DATA_WIDTH-1:0] InstrAD,
  output logic [DATA_WIDTH-1:0] InstrBD,
  output logic                  ValidAD,
  output logic                  ValidBD,
  output logic [DATA_WIDTH-1:0] PCAD,
  output logic [DATA_WIDTH-1:0] PCBD,
  output logic [CNT_WIDTH-1:0]  DualCount,
  output logic [CNT_WIDTH-1:0]  SingleCount
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0] opcode_a, opcode_b;
  logic [4:0] rd_a, rs1_b, rs2_b;
  logic       a_writes_rd, b_reads_rs1, b_reads_rs2;
  logic       a_is_ctrl, a_is_mem, b_is_mem;
  logic       raw_hazard, conflict, pair;

  always_comb begin
    opcode_a = InstrA[6:0];
    opcode_b = InstrB[6:0];
    rd_a     = InstrA[11:7];
    rs1_b    = InstrB[19:15];
    rs2_b    = InstrB[24:20];

    a_writes_rd = 1'b0;
    case (opcode_a)
      OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: a_writes_rd = 1'b1;
      default: a_writes_rd = 1'b0;
    endcase

    b_reads_rs1 = 1'b0;
    case (opcode_b)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: b_reads_rs1 = 1'b1;
      default: b_reads_rs1 = 1'b0;
    endcase

    b_reads_rs2 = 1'b0;
    case (opcode_b)
      OP_REG, OP_STORE, OP_BRANCH: b_reads_rs2 = 1'b1;
      default: b_reads_rs2 = 1'b0;
    endcase

    a_is_ctrl = (opcode_a == OP_BRANCH) || (opcode_a == OP_JAL) || (opcode_a == OP_JALR);
    a_is_mem  = (opcode_a == OP_LOAD) || (opcode_a == OP_STORE);
    b_is_mem  = (opcode_b == OP_LOAD) || (opcode_b == OP_STORE);

    // x0 is never a real producer, so a write to it cannot create a dependency.
    raw_hazard = a_writes_rd && (rd_a != 5'd0) &&
                 ((b_reads_rs1 && (rd_a == rs1_b)) || (b_reads_rs2 && (rd_a == rs2_b)));

    conflict = raw_hazard || a_is_ctrl || (a_is_mem && b_is_mem);
    pair     = !conflict;

    IncrSrc = pair;
    PCSrc   = StallD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstrAD     <= NOP_INSTR;
      InstrBD     <= NOP_INSTR;
      ValidAD     <= 1'b0;
      ValidBD     <= 1'b0;
      PCAD        <= '0;
      PCBD        <= '0;
      DualCount   <= '0;
      SingleCount <= '0;
    end else if (FlushD) begin
      InstrAD <= NOP_INSTR;
      InstrBD <= NOP_INSTR;
      ValidAD <= 1'b0;
      ValidBD <= 1'b0;
    end else if (!StallD) begin
      InstrAD <= InstrA;
      ValidAD <= 1'b1;
      PCAD    <= PCF;
      PCBD    <= PCF + DATA_WIDTH'(4);
      if (pair) begin
        InstrBD <= InstrB;
        ValidBD <= 1'b1;
        if (DualCount != '1) DualCount <= DualCount + CNT_WIDTH'(1);
      end else begin
        // Split pair: fetch advances by 4, so InstrB comes back as the next InstrA.
        InstrBD <= NOP_INSTR;
        ValidBD <= 1'b0;
        if (SingleCount != '1) SingleCount <= SingleCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_pair_reg.sv
// Testbench for dual_issue_pair_reg: directed cases plus random stimulus.
// Expected post-edge state is pushed into a queue and checked by a monitor.
// A second instance with 4-bit counters exercises saturation.
module tb_dual_issue_pair_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic [31:0] InstrA = 32'h0, InstrB = 32'h0, PCF = 32'h0;

  logic        IncrSrc, PCSrc, ValidAD, ValidBD;
  logic [31:0] InstrAD, InstrBD, PCAD, PCBD, DualCount, SingleCount;

  logic        IncrSrc4, PCSrc4, ValidAD4, ValidBD4;
  logic [31:0] InstrAD4, InstrBD4, PCAD4, PCBD4;
  logic [3:0]  DualCount4, SingleCount4;

  dual_issue_pair_reg dut (
    .clk(clk), .rst(rst), .InstrA(InstrA), .InstrB(InstrB), .PCF(PCF),
    .StallD(StallD), .FlushD(FlushD), .IncrSrc(IncrSrc), .PCSrc(PCSrc),
    .InstrAD(InstrAD), .InstrBD(InstrBD), .ValidAD(ValidAD), .ValidBD(ValidBD),
    .PCAD(PCAD), .PCBD(PCBD), .DualCount(DualCount), .SingleCount(SingleCount)
  );

  dual_issue_pair_reg #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .InstrA(InstrA), .InstrB(InstrB), .PCF(PCF),
    .StallD(StallD), .FlushD(FlushD), .IncrSrc(IncrSrc4), .PCSrc(PCSrc4),
    .InstrAD(InstrAD4), .InstrBD(InstrBD4), .ValidAD(ValidAD4), .ValidBD(ValidBD4),
    .PCAD(PCAD4), .PCBD(PCBD4), .DualCount(DualCount4), .SingleCount(SingleCount4)
  );

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0]     ia, ib, pa, pb;
    bit              va, vb;
    longint unsigned dc, sc;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  function automatic logic [63:0] sat(input longint unsigned c, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (c > mx) ? mx : c;
  endfunction

  // Pairing rule written directly from the instruction-class tables.
  function automatic bit model_pair(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] oa, ob;
    logic [4:0] rda, r1b, r2b;
    bit wr, rd1, rd2, raw, ctl, mem;
    oa = a[6:0];  ob = b[6:0];
    rda = a[11:7]; r1b = b[19:15]; r2b = b[24:20];
    wr  = oa inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    rd1 = ob inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    rd2 = ob inside {7'h33, 7'h23, 7'h63};
    raw = wr && (rda != 0) && ((rd1 && rda == r1b) || (rd2 && rda == r2b));
    ctl = oa inside {7'h63, 7'h6F, 7'h67};
    mem = (oa inside {7'h03, 7'h23}) && (ob inside {7'h03, 7'h23});
    return !(raw || ctl || mem);
  endfunction

  // Apply one cycle of inputs, check the combinational selects, push expected state.
  task automatic step(input bit r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input bit st, input bit fl);
    bit p;
    @(negedge clk);
    rst = r; InstrA = a; InstrB = b; PCF = pc; StallD = st; FlushD = fl;
    #1;
    p = model_pair(a, b);
    chk("IncrSrc", {63'd0, IncrSrc}, {63'd0, p});
    chk("PCSrc", {63'd0, PCSrc}, {63'd0, st});
    chk("IncrSrc_c4", {63'd0, IncrSrc4}, {63'd0, p});
    if (r) begin
      m.ia = NOP; m.ib = NOP; m.va = 0; m.vb = 0; m.pa = 0; m.pb = 0; m.dc = 0; m.sc = 0;
    end else if (fl) begin
      m.ia = NOP; m.ib = NOP; m.va = 0; m.vb = 0;
    end else if (!st) begin
      m.ia = a; m.va = 1; m.pa = pc; m.pb = pc + 32'd4;
      if (p) begin m.ib = b; m.vb = 1; m.dc++; end
      else   begin m.ib = NOP; m.vb = 0; m.sc++; end
    end
    q.push_back(m);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare registered outputs against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("InstrAD", {32'd0, InstrAD}, {32'd0, e.ia});
        chk("InstrBD", {32'd0, InstrBD}, {32'd0, e.ib});
        chk("ValidAD", {63'd0, ValidAD}, {63'd0, e.va});
        chk("ValidBD", {63'd0, ValidBD}, {63'd0, e.vb});
        chk("PCAD", {32'd0, PCAD}, {32'd0, e.pa});
        chk("PCBD", {32'd0, PCBD}, {32'd0, e.pb});
        chk("DualCount", {32'd0, DualCount}, sat(e.dc, 32));
        chk("SingleCount", {32'd0, SingleCount}, sat(e.sc, 32));
        chk("DualCount_c4", {60'd0, DualCount4}, sat(e.dc, 4));
        chk("SingleCount_c4", {60'd0, SingleCount4}, sat(e.sc, 4));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    int waited;
    // Reset for two cycles with arbitrary inputs.
    step(1, 32'hDEADBEEF, 32'h12345678, 32'h40, 0, 0);
    step(1, 32'h0000006F, 32'hFFFFFFFF, 32'h80, 1, 1);
    post();
    chk("rst_ValidAD", {63'd0, ValidAD}, 64'd0);
    chk("rst_InstrBD", {32'd0, InstrBD}, 64'h13);
    chk("rst_SingleCount", {32'd0, SingleCount}, 64'd0);

    // Independent pair.
    step(0, 32'h00500093, 32'h00700113, 32'h0, 0, 0);
    chk("indep_incr", {63'd0, IncrSrc}, 64'd1);
    post();
    chk("indep_InstrBD", {32'd0, InstrBD}, 64'h00700113);
    chk("indep_PCBD", {32'd0, PCBD}, 64'h4);
    chk("indep_DualCount", {32'd0, DualCount}, 64'd1);

    // RAW split.
    step(0, 32'h00500093, 32'h002081B3, 32'h10, 0, 0);
    chk("raw_incr", {63'd0, IncrSrc}, 64'd0);
    post();
    chk("raw_ValidBD", {63'd0, ValidBD}, 64'd0);
    chk("raw_PCAD", {32'd0, PCAD}, 64'h10);
    chk("raw_SingleCount", {32'd0, SingleCount}, 64'd1);

    // x0 destination pairs; two loads split.
    step(0, 32'h00100013, 32'h000001B3, 32'h14, 0, 0);
    chk("x0_incr", {63'd0, IncrSrc}, 64'd1);
    step(0, 32'h0002A083, 32'h00432103, 32'h1C, 0, 0);
    chk("mem_incr", {63'd0, IncrSrc}, 64'd0);

    // Stall three cycles, then stall with flush.
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h00500093, 32'h00700113, 32'h100 + 32'(i * 8), 1, 0);
      chk("stall_PCSrc", {63'd0, PCSrc}, 64'd1);
    end
    step(0, 32'h00500093, 32'h00700113, 32'h200, 1, 1);
    post();
    chk("flush_ValidAD", {63'd0, ValidAD}, 64'd0);
    chk("flush_DualCount", {32'd0, DualCount}, 64'd2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), rand_instr(), rand_instr(), $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end

    // Saturation on the 4-bit counter build.
    step(1, 32'h0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 32'h00500093, 32'h002081B3, 32'(i * 4), 0, 0);
    post();
    chk("sat_SingleCount_c4", {60'd0, SingleCount4}, 64'hF);
    chk("sat_SingleCount", {32'd0, SingleCount}, 64'd17);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_pair_reg.md
Name: dual_issue_pair_reg

Overview:
- Fetch/decode boundary register for the dual-issue front end; sits directly downstream of the fetch stage.
- Each cycle, classifies the fetched instruction pair (InstrA at PCF, InstrB at PCF+4) as dual-issuable or single-issue.
- Drives the fetch stage's IncrSrc (advance PC by 4 or 8) and PCSrc (hold PC) selects.
- Registers the issued slot(s) with valid bits, stall/flush control and issue-statistics counters.

Parameters:
- DATA_WIDTH, 32, instruction/PC width.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).
- CNT_WIDTH, 32, width of each issue-statistics counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- InstrA  input  DATA_WIDTH  fetched instruction at PCF.
- InstrB  input  DATA_WIDTH  fetched instruction at PCF+4.
- PCF  input  DATA_WIDTH  PC of InstrA.
- StallD  input  1  hold the decode register and the fetch PC.
- FlushD  input  1  squash the decode register contents.
- IncrSrc  output  1  to fetch: 1 = PC+8 (pair issued), 0 = PC+4.
- PCSrc  output  1  to fetch: 1 = hold PC; equals StallD.
- InstrAD  output  DATA_WIDTH  registered slot-A instruction.
- InstrBD  output  DATA_WIDTH  registered slot-B instruction.
- ValidAD  output  1  slot A holds a real instruction.
- ValidBD  output  1  slot B holds a real instruction.
- PCAD  output  DATA_WIDTH  PC of slot A.
- PCBD  output  DATA_WIDTH  PC of slot B (PCAD+4).
- DualCount  output  CNT_WIDTH  count of pair issues.
- SingleCount  output  CNT_WIDTH  count of single issues.

Behaviour:
- Field decode (combinational, on InstrA/InstrB): opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- A writes rd when its opcode is one of: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
- B reads rs1 when its opcode is one of: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- B reads rs2 when its opcode is one of: 0110011, 0100011, 1100011.
- Conflict is asserted if any of the following hold:
  - RAW: A writes rd, rdA != 0, and rdA matches an rs field that B reads.
  - A is control flow (1100011, 1101111, 1100111).
  - Both A and B are memory ops (0000011 or 0100011).
- pair = !conflict.
- IncrSrc = pair (combinational, no latency).
- PCSrc = StallD (combinational).
- Register update priority, at each rising edge of clk:
  1. rst: InstrAD = InstrBD = NOP_INSTR; ValidAD = ValidBD = 0; PCAD = PCBD = 0; both counters = 0.
  2. FlushD (overrides StallD): InstrAD = InstrBD = NOP_INSTR; ValidAD = ValidBD = 0; PCs and counters unchanged.
  3. StallD: all registers hold.
  4. Otherwise (load): InstrAD = InstrA; ValidAD = 1; PCAD = PCF; PCBD = PCF+4 (mod 2^DATA_WIDTH).
     - If pair: InstrBD = InstrB, ValidBD = 1, DualCount += 1.
     - If not pair: InstrBD = NOP_INSTR, ValidBD = 0, SingleCount += 1.
- Counters saturate at all-ones and never wrap.
- Latency: one cycle from fetch inputs to the D outputs.
- Reset asserted mid-stall or mid-flush: reset values take effect on the next edge.
- When the pair is split, the fetch stage advances only 4, so InstrB is re-fetched as the next InstrA; this block keeps no replay state.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> ValidAD=ValidBD=0, InstrAD=InstrBD=0x00000013, PCAD=PCBD=0, DualCount=SingleCount=0.
- Independent pair: InstrA=0x00500093, InstrB=0x00700113, PCF=0x0 -> IncrSrc=1 immediately; after the edge InstrAD=0x00500093, InstrBD=0x00700113, ValidBD=1, PCBD=0x4, DualCount=1.
- RAW split: InstrA=0x00500093, InstrB=0x002081B3, PCF=0x10 -> IncrSrc=0; after the edge ValidAD=1, ValidBD=0, InstrBD=0x00000013, PCAD=0x10, SingleCount=1.
- x0 destination and memory rule:
  - InstrA=0x00100013, InstrB=0x000001B3 -> IncrSrc=1 (paired).
  - Then InstrA=0x0002A083, InstrB=0x00432103 -> IncrSrc=0 (two loads).
- Stall then flush:
  - StallD=1 for 3 cycles -> PCSrc=1, all D outputs and counters frozen.
  - Then StallD=1 with FlushD=1 -> ValidAD=ValidBD=0, counters unchanged.
- Saturation: preload SingleCount to all-ones (CNT_WIDTH=4 build) and issue one split pair -> SingleCount stays 4'hF.
